// File: rtl/axis_tx_rr_arbiter.sv
// Packet-atomic two-input round-robin AXI-stream arbiter with a maximum packet length.
// Over-length packets get a forced tlast on the output; their tail is drained in DROP.
module axis_tx_rr_arbiter #(
  parameter int unsigned AXIS_BUS_WIDTH    = 64,
  parameter int unsigned AXIS_ID_WIDTH     = 3,
  parameter int unsigned AXIS_DEST_WIDTH   = 1,
  parameter int unsigned MAX_PACKET_LENGTH = 1522
) (
  input  logic                         aclk,
  input  logic                         areset,

  input  logic [AXIS_BUS_WIDTH-1:0]    axis_in_0_tdata,
  input  logic [AXIS_ID_WIDTH-1:0]     axis_in_0_tid,
  input  logic [AXIS_DEST_WIDTH-1:0]   axis_in_0_tdest,
  input  logic [AXIS_BUS_WIDTH/8-1:0]  axis_in_0_tkeep,
  input  logic                         axis_in_0_tlast,
  input  logic                         axis_in_0_tvalid,
  output logic                         axis_in_0_tready,

  input  logic [AXIS_BUS_WIDTH-1:0]    axis_in_1_tdata,
  input  logic [AXIS_ID_WIDTH-1:0]     axis_in_1_tid,
  input  logic [AXIS_DEST_WIDTH-1:0]   axis_in_1_tdest,
  input  logic [AXIS_BUS_WIDTH/8-1:0]  axis_in_1_tkeep,
  input  logic                         axis_in_1_tlast,
  input  logic                         axis_in_1_tvalid,
  output logic                         axis_in_1_tready,

  output logic [AXIS_BUS_WIDTH-1:0]    axis_out_tdata,
  output logic [AXIS_ID_WIDTH-1:0]     axis_out_tid,
  output logic [AXIS_DEST_WIDTH-1:0]   axis_out_tdest,
  output logic [AXIS_BUS_WIDTH/8-1:0]  axis_out_tkeep,
  output logic                         axis_out_tlast,
  output logic                         axis_out_tvalid,
  input  logic                         axis_out_tready,

  input  logic [1:0]                   enable,
  output logic [1:0]                   grant,
  output logic [1:0]                   trunc_pulse
);

  localparam int unsigned KEEP_W    = AXIS_BUS_WIDTH / 8;
  localparam int unsigned MAX_BEATS = (MAX_PACKET_LENGTH + KEEP_W - 1) / KEEP_W;
  localparam int unsigned CNT_W     = $clog2(MAX_BEATS) + 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PASS = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]       r_state, w_state_nxt;
  logic [1:0]       r_grant, w_grant_nxt;
  logic             r_last,  w_last_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [1:0]       r_trunc, w_trunc_nxt;

  logic                        w_sel;
  logic [AXIS_BUS_WIDTH-1:0]   w_sel_tdata;
  logic [AXIS_ID_WIDTH-1:0]    w_sel_tid;
  logic [AXIS_DEST_WIDTH-1:0]  w_sel_tdest;
  logic [KEEP_W-1:0]           w_sel_tkeep;
  logic                        w_sel_tlast;
  logic                        w_sel_tvalid;
  logic [1:0]                  w_req;
  logic                        w_at_max;
  logic                        w_in_ready;
  logic                        w_out_hs;

  // Owner select: grant is one-hot, so bit 1 picks input 1.
  assign w_sel        = r_grant[1];
  assign w_sel_tdata  = w_sel ? axis_in_1_tdata  : axis_in_0_tdata;
  assign w_sel_tid    = w_sel ? axis_in_1_tid    : axis_in_0_tid;
  assign w_sel_tdest  = w_sel ? axis_in_1_tdest  : axis_in_0_tdest;
  assign w_sel_tkeep  = w_sel ? axis_in_1_tkeep  : axis_in_0_tkeep;
  assign w_sel_tlast  = w_sel ? axis_in_1_tlast  : axis_in_0_tlast;
  assign w_sel_tvalid = w_sel ? axis_in_1_tvalid : axis_in_0_tvalid;

  assign w_req    = {axis_in_1_tvalid & enable[1], axis_in_0_tvalid & enable[0]};
  assign w_at_max = (r_cnt == LAST_BEAT);
  assign w_out_hs = axis_out_tvalid & axis_out_tready;

  // Output passthrough and input ready steering.
  always_comb begin
    axis_out_tdata  = w_sel_tdata;
    axis_out_tid    = w_sel_tid;
    axis_out_tdest  = w_sel_tdest;
    axis_out_tkeep  = w_sel_tkeep;
    axis_out_tvalid = 1'b0;
    axis_out_tlast  = 1'b0;
    w_in_ready      = 1'b0;
    case (r_state)
      PASS: begin
        axis_out_tvalid = w_sel_tvalid;
        axis_out_tlast  = w_sel_tlast | w_at_max;
        w_in_ready      = axis_out_tready;
      end
      DROP:    w_in_ready = 1'b1;
      default: w_in_ready = 1'b0;
    endcase
    axis_in_0_tready = w_in_ready & r_grant[0];
    axis_in_1_tready = w_in_ready & r_grant[1];
  end

  // Next-state logic; a truncating beat only counts when the input's own tlast is low.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_trunc_nxt = 2'b00;
    case (r_state)
      IDLE: begin
        if (w_req == 2'b11) begin
          w_grant_nxt = r_last ? 2'b01 : 2'b10;
          w_state_nxt = PASS;
        end else if (w_req != 2'b00) begin
          w_grant_nxt = w_req;
          w_state_nxt = PASS;
        end
      end
      PASS: begin
        if (w_out_hs) begin
          if (w_sel_tlast) begin
            w_last_nxt  = w_sel;
            w_cnt_nxt   = '0;
            w_grant_nxt = 2'b00;
            w_state_nxt = IDLE;
          end else if (w_at_max) begin
            w_trunc_nxt = r_grant;
            w_cnt_nxt   = '0;
            w_state_nxt = DROP;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      DROP: begin
        if (w_sel_tvalid && w_sel_tlast) begin
          w_last_nxt  = w_sel;
          w_cnt_nxt   = '0;
          w_grant_nxt = 2'b00;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_grant_nxt = 2'b00;
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register; r_last resets to 1 so input 0 wins the first contention.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= IDLE;
      r_grant <= 2'b00;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_trunc <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_trunc <= w_trunc_nxt;
    end
  end

  assign grant       = r_grant;
  assign trunc_pulse = r_trunc;

endmodule

// File: tb/tb_axis_tx_rr_arbiter.sv
// Directed bench for axis_tx_rr_arbiter with MAX_PACKET_LENGTH=64 (8 beats of 8 bytes).
// Sources are simple beat queues; output handshakes are captured and compared in order.
module tb_axis_tx_rr_arbiter;
  localparam int unsigned W   = 64;
  localparam int unsigned KW  = W / 8;
  localparam int unsigned IDW = 3;
  localparam int unsigned DSW = 1;

  typedef struct packed {
    logic [W-1:0]   data;
    logic [KW-1:0]  keep;
    logic [IDW-1:0] id;
    logic [DSW-1:0] dest;
    logic           last;
  } beat_t;

  logic           aclk = 1'b0;
  logic           areset;
  logic [W-1:0]   in_tdata  [2];
  logic [IDW-1:0] in_tid    [2];
  logic [DSW-1:0] in_tdest  [2];
  logic [KW-1:0]  in_tkeep  [2];
  logic [1:0]     in_tlast;
  logic [1:0]     in_tvalid;
  logic [1:0]     in_tready;
  logic [W-1:0]   out_tdata;
  logic [IDW-1:0] out_tid;
  logic [DSW-1:0] out_tdest;
  logic [KW-1:0]  out_tkeep;
  logic           out_tlast;
  logic           out_tvalid;
  logic           out_tready;
  logic [1:0]     enable;
  logic [1:0]     grant;
  logic [1:0]     trunc_pulse;

  beat_t src_q0[$];
  beat_t src_q1[$];
  beat_t cap_q[$];
  int    cap_cyc[$];
  int    cycle;
  int    checks;
  int    errors;
  int    trunc_cnt0;
  int    trunc_cnt1;
  int    bad_rdy0;
  int    bad_rdy1;
  int    mirror_bad;
  bit    rand_rdy;
  bit    mirror_on;
  int    exp_off[8] = '{0, 1, 3, 4, 6, 7, 9, 10};
  beat_t e;

  always #5 aclk = ~aclk;

  axis_tx_rr_arbiter #(
    .AXIS_BUS_WIDTH(W), .AXIS_ID_WIDTH(IDW), .AXIS_DEST_WIDTH(DSW), .MAX_PACKET_LENGTH(64)
  ) dut (
    .aclk(aclk), .areset(areset),
    .axis_in_0_tdata(in_tdata[0]), .axis_in_0_tid(in_tid[0]), .axis_in_0_tdest(in_tdest[0]),
    .axis_in_0_tkeep(in_tkeep[0]), .axis_in_0_tlast(in_tlast[0]), .axis_in_0_tvalid(in_tvalid[0]),
    .axis_in_0_tready(in_tready[0]),
    .axis_in_1_tdata(in_tdata[1]), .axis_in_1_tid(in_tid[1]), .axis_in_1_tdest(in_tdest[1]),
    .axis_in_1_tkeep(in_tkeep[1]), .axis_in_1_tlast(in_tlast[1]), .axis_in_1_tvalid(in_tvalid[1]),
    .axis_in_1_tready(in_tready[1]),
    .axis_out_tdata(out_tdata), .axis_out_tid(out_tid), .axis_out_tdest(out_tdest),
    .axis_out_tkeep(out_tkeep), .axis_out_tlast(out_tlast), .axis_out_tvalid(out_tvalid),
    .axis_out_tready(out_tready),
    .enable(enable), .grant(grant), .trunc_pulse(trunc_pulse)
  );

  function automatic beat_t mk(input logic [7:0] tag, input int i, input int n);
    beat_t b;
    b.data = W'({tag, 8'(i)});
    b.keep = KW'(8'hFF ^ 8'(i));
    b.id   = tag[2:0];
    b.dest = tag[4];
    b.last = (i == n - 1);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input int k, input beat_t exp);
    beat_t obs;
    obs = (k < cap_q.size()) ? cap_q[k] : '0;
    chk($sformatf("%s_beat%0d", tag, k), 128'(obs), 128'(exp));
  endtask

  task automatic load(input int port, input logic [7:0] tag, input int n);
    for (int i = 0; i < n; i++) begin
      if (port == 0) src_q0.push_back(mk(tag, i, n));
      else           src_q1.push_back(mk(tag, i, n));
    end
  endtask

  task automatic drive();
    beat_t b0;
    beat_t b1;
    b0 = (src_q0.size() != 0) ? src_q0[0] : '0;
    b1 = (src_q1.size() != 0) ? src_q1[0] : '0;
    in_tvalid   = {src_q1.size() != 0, src_q0.size() != 0};
    in_tdata[0] = b0.data; in_tkeep[0] = b0.keep; in_tid[0] = b0.id;
    in_tdest[0] = b0.dest; in_tlast[0] = b0.last;
    in_tdata[1] = b1.data; in_tkeep[1] = b1.keep; in_tid[1] = b1.id;
    in_tdest[1] = b1.dest; in_tlast[1] = b1.last;
  endtask

  // One clock: observe settled handshakes, advance the edge, update sources.
  task automatic cyc();
    logic hs0;
    logic hs1;
    hs0 = in_tvalid[0] & in_tready[0];
    hs1 = in_tvalid[1] & in_tready[1];
    if (out_tvalid && out_tready) begin
      cap_q.push_back('{out_tdata, out_tkeep, out_tid, out_tdest, out_tlast});
      cap_cyc.push_back(cycle);
    end
    if (trunc_pulse[0]) trunc_cnt0++;
    if (trunc_pulse[1]) trunc_cnt1++;
    if (in_tready[0] && grant != 2'b01) bad_rdy0++;
    if (in_tready[1] && grant != 2'b10) bad_rdy1++;
    if (mirror_on && grant != 2'b00 && (in_tready[grant[1]] !== out_tready)) mirror_bad++;
    @(posedge aclk);
    #1;
    cycle++;
    if (hs0 && src_q0.size() != 0) src_q0.delete(0);
    if (hs1 && src_q1.size() != 0) src_q1.delete(0);
    if (rand_rdy) out_tready = 1'($urandom_range(0, 1));
    drive();
    #1;
  endtask

  task automatic run_until_cap(input string tag, input int n, input int budget);
    for (int k = 0; k < budget && cap_q.size() < n; k++) cyc();
    chk({tag, "_count"}, 128'(cap_q.size()), 128'(n));
  endtask

  task automatic run_until_empty(input string tag, input int budget);
    for (int k = 0; k < budget && (src_q0.size() != 0 || src_q1.size() != 0); k++) cyc();
    chk({tag, "_drained"}, 128'(src_q0.size() + src_q1.size()), 128'(0));
  endtask

  task automatic do_reset();
    areset = 1'b1;
    cyc();
    areset = 1'b0;
    #1;
  endtask

  task automatic clear_cap();
    cap_q.delete();
    cap_cyc.delete();
  endtask

  initial begin
    checks = 0; errors = 0; cycle = 0;
    trunc_cnt0 = 0; trunc_cnt1 = 0; bad_rdy0 = 0; bad_rdy1 = 0; mirror_bad = 0;
    rand_rdy = 1'b0; mirror_on = 1'b0;
    areset = 1'b1; enable = 2'b00; out_tready = 1'b0;
    drive();
    cyc();
    cyc();
    chk("rst_grant", 128'(grant), 128'(2'b00));
    chk("rst_tvalid", 128'(out_tvalid), 128'(1'b0));
    chk("rst_tready", 128'(in_tready), 128'(2'b00));
    chk("rst_trunc", 128'(trunc_pulse), 128'(2'b00));
    areset = 1'b0;
    #1;

    // Single 3-beat packet on input 0
    enable = 2'b11; out_tready = 1'b1;
    clear_cap();
    load(0, 8'hA1, 3);
    drive(); #1;
    chk("t1_idle_grant", 128'(grant), 128'(2'b00));
    chk("t1_idle_rdy0", 128'(in_tready[0]), 128'(1'b0));
    cyc();
    chk("t1_grant", 128'(grant), 128'(2'b01));
    chk("t1_tvalid", 128'(out_tvalid), 128'(1'b1));
    chk("t1_tdata0", 128'(out_tdata), 128'(mk(8'hA1, 0, 3).data));
    run_until_cap("t1", 3, 20);
    for (int k = 0; k < 3; k++) chk_beat("t1", k, mk(8'hA1, k, 3));
    chk("t1_end_grant", 128'(grant), 128'(2'b00));
    chk("t1_end_tvalid", 128'(out_tvalid), 128'(1'b0));

    // Contention from reset: alternation with a one-cycle bubble
    do_reset();
    clear_cap();
    load(0, 8'h20, 2); load(0, 8'h21, 2);
    load(1, 8'h30, 2); load(1, 8'h31, 2);
    drive(); #1;
    run_until_cap("t2", 8, 60);
    chk_beat("t2", 0, mk(8'h20, 0, 2)); chk_beat("t2", 1, mk(8'h20, 1, 2));
    chk_beat("t2", 2, mk(8'h30, 0, 2)); chk_beat("t2", 3, mk(8'h30, 1, 2));
    chk_beat("t2", 4, mk(8'h21, 0, 2)); chk_beat("t2", 5, mk(8'h21, 1, 2));
    chk_beat("t2", 6, mk(8'h31, 0, 2)); chk_beat("t2", 7, mk(8'h31, 1, 2));
    for (int k = 1; k < 8; k++)
      chk($sformatf("t2_offset%0d", k), 128'(cap_cyc.size() == 8 ? cap_cyc[k] - cap_cyc[0] : -1),
          128'(exp_off[k]));

    // Enable fencing: in0 held off until in1's packet ends
    do_reset();
    clear_cap();
    enable = 2'b10;
    load(0, 8'h40, 2); load(1, 8'h50, 3);
    drive(); #1;
    cyc();
    chk("t3_grant", 128'(grant), 128'(2'b10));
    chk("t3_rdy0", 128'(in_tready[0]), 128'(1'b0));
    run_until_cap("t3a", 1, 10);
    enable = 2'b11;
    run_until_cap("t3", 5, 40);
    chk_beat("t3", 0, mk(8'h50, 0, 3)); chk_beat("t3", 1, mk(8'h50, 1, 3));
    chk_beat("t3", 2, mk(8'h50, 2, 3)); chk_beat("t3", 3, mk(8'h40, 0, 2));
    chk_beat("t3", 4, mk(8'h40, 1, 2));

    // 12-beat packet truncated to 8 beats, tail dropped
    clear_cap();
    trunc_cnt0 = 0; trunc_cnt1 = 0;
    load(0, 8'h60, 12);
    drive(); #1;
    run_until_empty("t4", 40);
    chk("t4_grant_idle", 128'(grant), 128'(2'b00));
    chk("t4_out_count", 128'(cap_q.size()), 128'(8));
    for (int k = 0; k < 8; k++) begin
      e = mk(8'h60, k, 12);
      e.last = (k == 7);
      chk_beat("t4", k, e);
    end
    chk("t4_trunc0", 128'(trunc_cnt0), 128'(1));
    chk("t4_trunc1", 128'(trunc_cnt1), 128'(0));

    // Exactly MAX_BEATS: normal completion
    clear_cap();
    trunc_cnt0 = 0;
    load(0, 8'h70, 8);
    drive(); #1;
    run_until_empty("t5", 30);
    chk("t5_grant_idle", 128'(grant), 128'(2'b00));
    chk("t5_out_count", 128'(cap_q.size()), 128'(8));
    for (int k = 0; k < 8; k++) chk_beat("t5", k, mk(8'h70, k, 8));
    chk("t5_trunc0", 128'(trunc_cnt0), 128'(0));

    // Random backpressure; in0 was served last so in1 goes first
    clear_cap();
    rand_rdy = 1'b1; mirror_on = 1'b1;
    load(1, 8'h80, 5); load(0, 8'h90, 5);
    drive(); #1;
    run_until_cap("t6", 10, 300);
    for (int k = 0; k < 5; k++) chk_beat("t6", k, mk(8'h80, k, 5));
    for (int k = 0; k < 5; k++) chk_beat("t6", k + 5, mk(8'h90, k, 5));
    chk("t6_mirror", 128'(mirror_bad), 128'(0));
    rand_rdy = 1'b0; mirror_on = 1'b0; out_tready = 1'b1;
    #1;

    // Reset on beat 3; afterwards in0 wins contention again
    clear_cap();
    load(0, 8'hA0, 5);
    drive(); #1;
    run_until_cap("t7a", 2, 20);
    areset = 1'b1; #1;
    cyc();
    chk("t7_rst_grant", 128'(grant), 128'(2'b00));
    chk("t7_rst_tvalid", 128'(out_tvalid), 128'(1'b0));
    chk("t7_rst_tready", 128'(in_tready), 128'(2'b00));
    load(1, 8'hB0, 2);
    areset = 1'b0;
    clear_cap();
    drive(); #1;
    chk("t7_idle_grant", 128'(grant), 128'(2'b00));
    cyc();
    chk("t7_grant", 128'(grant), 128'(2'b01));
    run_until_cap("t7", 4, 30);
    chk_beat("t7", 0, mk(8'hA0, 3, 5)); chk_beat("t7", 1, mk(8'hA0, 4, 5));
    chk_beat("t7", 2, mk(8'hB0, 0, 2)); chk_beat("t7", 3, mk(8'hB0, 1, 2));

    chk("ready0_only_when_owner", 128'(bad_rdy0), 128'(0));
    chk("ready1_only_when_owner", 128'(bad_rdy1), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
